// File: rtl/xm_pkg.sv
// Shared constants and helpers for the XM expansion block: register offsets,
// control bit positions and the register-offset decoder.
package xm_pkg;

  // Register offsets within the 16-byte XM register block
  localparam logic [3:0] XC1_OFS = 4'h0;
  localparam logic [3:0] XC2_OFS = 4'h8;
  localparam logic [3:0] XC3_OFS = 4'hC;
  localparam logic [3:0] XC4_OFS = 4'h1;
  localparam logic [3:0] XC5_OFS = 4'h2;

  // XCTRL1 bit positions
  localparam int ROF_LO  = 0;
  localparam int ROF_HI  = 1;
  localparam int TOPSLOT = 2;
  localparam int HSC     = 3;
  localparam int POKEY   = 4;
  localparam int BANK0   = 5;
  localparam int BANK1   = 6;
  localparam int YM      = 7;

  // XCTRL4 bit positions
  localparam int X4_TOP_LOCK = 7;

  // XCTRL5 bit positions; bits 3..5 can only be set, never cleared by software
  localparam int X5_WR_DIS     = 1;
  localparam int X5_POKEY_LOCK = 3;
  localparam int X5_HSC_LOCK   = 4;
  localparam int X5_LOCK5      = 5;
  localparam logic [7:0] X5_STICKY_MASK = 8'h38;

  // Default register block location, address_in[15:4]
  localparam logic [11:0] XM_BASE_DEF = 12'h047;

  typedef enum logic [2:0] {
    REG_XC1,
    REG_XC2,
    REG_XC3,
    REG_XC4,
    REG_XC5,
    REG_NONE
  } xreg_e;

  // Map a low-nibble offset onto the register it selects
  function automatic xreg_e decode_ofs(input logic [3:0] ofs);
    xreg_e r;
    case (ofs)
      XC1_OFS: r = REG_XC1;
      XC2_OFS: r = REG_XC2;
      XC3_OFS: r = REG_XC3;
      XC4_OFS: r = REG_XC4;
      XC5_OFS: r = REG_XC5;
      default: r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xm_wbuf.sv
// Synchronous FIFO used as the posted-write buffer for XM RAM writes.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module xm_wbuf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/xm_expansion.sv
// XM expansion: XCTRL1..5 register file with lock rules, banked RAM window at
// $4000-$7FFF with separate Sally/Maria page selection, and a posted-write
// buffer that drains to external memory through a req/ack handshake.
module xm_expansion
  import xm_pkg::*;
#(
  parameter int          RAM_PAGES  = 16,
  parameter int          PAGE_W     = $clog2(RAM_PAGES),
  parameter int          WBUF_DEPTH = 4,
  parameter logic [11:0] XM_BASE    = XM_BASE_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pclk0,
  input  logic              xm_en,
  input  logic              cart_cs,
  input  logic [15:0]       address_in,
  input  logic [7:0]        din,
  input  logic              rw,
  input  logic              halt_n,
  output logic [7:0]        xctrl1,
  output logic [7:0]        xctrl2,
  output logic [7:0]        xctrl3,
  output logic [7:0]        xctrl4,
  output logic [7:0]        xctrl5,
  output logic              pokey_en,
  output logic              ym_en,
  output logic              hsc_en,
  output logic              xm_hit,
  output logic [PAGE_W+12:0] xm_addr,
  output logic              rd_stall,
  output logic              wr_req,
  output logic [PAGE_W+12:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  output logic              wbuf_ovf
);

  localparam int ADDR_W = PAGE_W + 13;
  localparam int ENT_W  = ADDR_W + 8;
  localparam int CNT_W  = $clog2(WBUF_DEPTH) + 1;

  logic              reg_we;
  xreg_e             reg_sel;
  logic              win_lo;
  logic              win_hi;
  logic [2:0]        nib_lsb;
  logic [PAGE_W-1:0] page;
  logic              push;
  logic              buf_full;
  logic              buf_empty;
  logic [CNT_W-1:0]  buf_count;
  logic [ENT_W-1:0]  head;

  // XCTRL1 write value after applying the POKEY, HSC and top-slot locks
  function automatic logic [7:0] lock_xc1(input logic [7:0] cur, input logic [7:0] wdata,
                                          input logic [7:0] xc4, input logic [7:0] xc5);
    logic [7:0] nv;
    nv = wdata;
    if (xc5[X5_POKEY_LOCK]) nv[POKEY]   = cur[POKEY];
    if (xc5[X5_HSC_LOCK])   nv[HSC]     = cur[HSC] | wdata[HSC];
    if (xc4[X4_TOP_LOCK])   nv[TOPSLOT] = cur[TOPSLOT];
    return nv;
  endfunction

  // XCTRL4 write value; once the top-slot lock is set it holds itself
  function automatic logic [7:0] lock_xc4(input logic [7:0] cur, input logic [7:0] wdata);
    logic [7:0] nv;
    nv = wdata;
    if (cur[X4_TOP_LOCK]) nv[X4_TOP_LOCK] = 1'b1;
    return nv;
  endfunction

  // XCTRL5 write value; lock bits accumulate until reset
  function automatic logic [7:0] lock_xc5(input logic [7:0] cur, input logic [7:0] wdata);
    return wdata | (cur & X5_STICKY_MASK);
  endfunction

  assign reg_we  = pclk0 & xm_en & cart_cs & ~rw & (address_in[15:4] == XM_BASE);
  assign reg_sel = decode_ofs(address_in[3:0]);

  // Register file update; locks consult the values held before this write
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      xctrl1 <= '0;
      xctrl2 <= '0;
      xctrl3 <= '0;
      xctrl4 <= '0;
      xctrl5 <= '0;
    end else if (reg_we) begin
      case (reg_sel)
        REG_XC1: xctrl1 <= lock_xc1(xctrl1, din, xctrl4, xctrl5);
        REG_XC2: xctrl2 <= din;
        REG_XC3: xctrl3 <= din;
        REG_XC4: xctrl4 <= lock_xc4(xctrl4, din);
        REG_XC5: xctrl5 <= lock_xc5(xctrl5, din);
        default: ;
      endcase
    end
  end

  assign pokey_en = xctrl1[POKEY];
  assign ym_en    = xctrl1[YM];
  assign hsc_en   = xctrl1[HSC];

  // Window decode: each 8 KB half has its own enable, A13 picks the nibble
  assign win_lo  = (address_in[15:13] == 3'd2) & xctrl1[BANK0];
  assign win_hi  = (address_in[15:13] == 3'd3) & xctrl1[BANK1];
  assign xm_hit  = xm_en & cart_cs & (win_lo | win_hi);
  assign nib_lsb = {address_in[13], 2'b00};
  assign page    = halt_n ? xctrl2[nib_lsb +: PAGE_W] : xctrl3[nib_lsb +: PAGE_W];
  assign xm_addr = {page, address_in[12:0]};

  assign push = pclk0 & xm_hit & ~rw & ~xctrl5[X5_WR_DIS];

  xm_wbuf #(
    .DATA_W (ENT_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk   (clk_sys),
    .reset (reset),
    .push  (push),
    .pop   (wr_ack),
    .din   ({xm_addr, din}),
    .dout  (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign wr_req   = ~buf_empty;
  assign wr_addr  = head[ENT_W-1:8];
  assign wr_data  = head[7:0];
  assign rd_stall = xm_hit & rw & (buf_count != '0);

  // Sticky overflow flag: a push found no room and nothing left this cycle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wbuf_ovf <= 1'b0;
    end else if (push & buf_full & ~wr_ack) begin
      wbuf_ovf <= 1'b1;
    end
  end

endmodule
